cmp_wide_serial_seq: RTL and testbench

Sequencer that sits directly upstream of the 8-bit signed comparator (Comparator8Bit). It compares two NBYTES-wide words by presenting them to the comparator one byte at a time, most significant byte (MS byte) first. It consumes the comparator's three result flags and stops at the first byte that differs. The final wide result is held on registered outputs, with a start/busy/done handshake.

---
 rtl/cmp_wide_serial_seq_if.sv | 42 ++++
 rtl/cmp_wide_serial_seq.sv | 135 +++++++++++++
 tb/tb_cmp_wide_serial_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_wide_serial_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cmp_wide_serial_seq_if                                            |
// | Brief  : Request/result and comparator-side signals of the wide sequencer. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface cmp_wide_serial_seq_if #(
  parameter int NBYTES = 4
);
  logic                  start_ip;
  logic [8*NBYTES-1:0]   a_word_ip;
  logic [8*NBYTES-1:0]   b_word_ip;
  logic                  busy_op;
  logic                  done_op;
  logic                  a_op_G;
  logic                  b_op_G;
  logic                  a_op_E_b;
  logic                  err_op;
  logic [7:0]            cmp_a_op;
  logic [7:0]            cmp_b_op;
  logic                  cmp_a_ip_G_op;
  logic                  cmp_b_ip_G_op;
  logic                  cmp_a_ip_E_b_op;
  logic                  cmp_a_op_G_ip;
  logic                  cmp_b_op_G_ip;
  logic                  cmp_a_op_E_b_ip;

  modport slave (
    input  start_ip, a_word_ip, b_word_ip,
    output busy_op, done_op, a_op_G, b_op_G, a_op_E_b, err_op,
    output cmp_a_op, cmp_b_op, cmp_a_ip_G_op, cmp_b_ip_G_op, cmp_a_ip_E_b_op,
    input  cmp_a_op_G_ip, cmp_b_op_G_ip, cmp_a_op_E_b_ip
  );

  modport master (
    output start_ip, a_word_ip, b_word_ip,
    input  busy_op, done_op, a_op_G, b_op_G, a_op_E_b, err_op,
    input  cmp_a_op, cmp_b_op, cmp_a_ip_G_op, cmp_b_ip_G_op, cmp_a_ip_E_b_op,
    output cmp_a_op_G_ip, cmp_b_op_G_ip, cmp_a_op_E_b_ip
  );
endinterface
`default_nettype wire

// File: rtl/cmp_wide_serial_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cmp_wide_serial_seq                                               |
// | Brief  : Wide compare by feeding an 8-bit signed comparator MS byte first. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module cmp_wide_serial_seq #(
  parameter int NBYTES = 4,
  parameter bit SIGNED = 1'b1
) (
  input  wire logic            clk_ip,
  input  wire logic            rst_ip,
  cmp_wide_serial_seq_if.slave bus
);

  localparam int         IDXW     = (NBYTES > 2) ? $clog2(NBYTES) : 1;
  localparam logic [7:0] c_ms_flip = SIGNED ? 8'h00 : 8'h80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_finish;
  logic [IDXW-1:0]     r_idx;
  logic [IDXW-1:0]     w_idx_dn;
  logic [8*NBYTES-1:0] r_a_word;
  logic [8*NBYTES-1:0] r_b_word;
  logic [7:0]          r_cmp_a;
  logic [7:0]          r_cmp_b;
  logic                r_a_g;
  logic                r_b_g;
  logic                r_eq;
  logic                r_err;
  logic [2:0]          w_flags;
  logic                w_one_hot;
  logic                w_differ;
  logic                w_last;

  assign w_flags   = {bus.cmp_a_op_G_ip, bus.cmp_b_op_G_ip, bus.cmp_a_op_E_b_ip};
  assign w_one_hot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
  // A malformed response is treated as "equal" so the scan keeps going.
  assign w_differ  = w_one_hot && !bus.cmp_a_op_E_b_ip;
  assign w_last    = (r_idx == '0);
  assign w_idx_dn  = r_idx - IDXW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_ip) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_differ || w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start_ip) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ip) begin
    if (rst_ip) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The comparator bytes are registered one step ahead so the byte for idx is
  // already on the bus during the RUN cycle that examines it.
  always_ff @(posedge clk_ip) begin
    if (rst_ip) begin
      r_idx    <= '0;
      r_a_word <= '0;
      r_b_word <= '0;
      r_cmp_a  <= 8'h00;
      r_cmp_b  <= 8'h00;
      r_a_g    <= 1'b0;
      r_b_g    <= 1'b0;
      r_eq     <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_a_word <= bus.a_word_ip;
      r_b_word <= bus.b_word_ip;
      r_idx    <= IDXW'(NBYTES - 1);
      r_cmp_a  <= bus.a_word_ip[8*NBYTES-1 -: 8] ^ c_ms_flip;
      r_cmp_b  <= bus.b_word_ip[8*NBYTES-1 -: 8] ^ c_ms_flip;
      r_err    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_err <= r_err | ~w_one_hot;
      if (w_finish) begin
        r_a_g <= w_differ ? bus.cmp_a_op_G_ip : 1'b0;
        r_b_g <= w_differ ? bus.cmp_b_op_G_ip : 1'b0;
        r_eq  <= ~w_differ;
      end else begin
        r_idx   <= w_idx_dn;
        r_cmp_a <= r_a_word[8*w_idx_dn +: 8] ^ 8'h80;
        r_cmp_b <= r_b_word[8*w_idx_dn +: 8] ^ 8'h80;
      end
    end
  end

  assign bus.busy_op         = (r_state == S_RUN);
  assign bus.done_op         = (r_state == S_DONE);
  assign bus.err_op          = (r_state == S_DONE) && r_err;
  assign bus.a_op_G          = r_a_g;
  assign bus.b_op_G          = r_b_g;
  assign bus.a_op_E_b        = r_eq;
  assign bus.cmp_a_op        = r_cmp_a;
  assign bus.cmp_b_op        = r_cmp_b;
  assign bus.cmp_a_ip_G_op   = 1'b0;
  assign bus.cmp_b_ip_G_op   = 1'b0;
  assign bus.cmp_a_ip_E_b_op = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_cmp_wide_serial_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_cmp_wide_serial_seq                                            |
// | Brief  : Bench for the wide serial comparator, signed and unsigned builds. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_cmp_wide_serial_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         drv_rst   = 1'b1;
  logic         drv_start = 1'b0;
  logic [W-1:0] drv_a     = '0;
  logic [W-1:0] drv_b     = '0;
  int           drv_inj   = NB;
  logic         inj_now   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  cmp_wide_serial_seq_if #(.NBYTES(NB)) bus0 ();
  cmp_wide_serial_seq_if #(.NBYTES(NB)) bus1 ();

  cmp_wide_serial_seq #(.NBYTES(NB), .SIGNED(1'b1)) dut_s (
    .clk_ip (clk),
    .rst_ip (drv_rst),
    .bus    (bus0)
  );

  cmp_wide_serial_seq #(.NBYTES(NB), .SIGNED(1'b0)) dut_u (
    .clk_ip (clk),
    .rst_ip (drv_rst),
    .bus    (bus1)
  );

  assign bus0.start_ip  = drv_start;
  assign bus0.a_word_ip = drv_a;
  assign bus0.b_word_ip = drv_b;
  assign bus1.start_ip  = drv_start;
  assign bus1.a_word_ip = drv_a;
  assign bus1.b_word_ip = drv_b;

  // Signed 8-bit comparator with cascade inputs; inj_now forces an all-zero response.
  assign bus0.cmp_a_op_G_ip   = !inj_now && (($signed(bus0.cmp_a_op) > $signed(bus0.cmp_b_op)) ||
                                ((bus0.cmp_a_op == bus0.cmp_b_op) && bus0.cmp_a_ip_G_op));
  assign bus0.cmp_b_op_G_ip   = !inj_now && (($signed(bus0.cmp_b_op) > $signed(bus0.cmp_a_op)) ||
                                ((bus0.cmp_a_op == bus0.cmp_b_op) && bus0.cmp_b_ip_G_op));
  assign bus0.cmp_a_op_E_b_ip = !inj_now && (bus0.cmp_a_op == bus0.cmp_b_op) && bus0.cmp_a_ip_E_b_op;
  assign bus1.cmp_a_op_G_ip   = !inj_now && (($signed(bus1.cmp_a_op) > $signed(bus1.cmp_b_op)) ||
                                ((bus1.cmp_a_op == bus1.cmp_b_op) && bus1.cmp_a_ip_G_op));
  assign bus1.cmp_b_op_G_ip   = !inj_now && (($signed(bus1.cmp_b_op) > $signed(bus1.cmp_a_op)) ||
                                ((bus1.cmp_a_op == bus1.cmp_b_op) && bus1.cmp_b_ip_G_op));
  assign bus1.cmp_a_op_E_b_ip = !inj_now && (bus1.cmp_a_op == bus1.cmp_b_op) && bus1.cmp_a_ip_E_b_op;

  // Reference model: each operation is planned whole at acceptance time.
  logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, p_err = 1'b0;
  logic [2:0]   m_res0 = '0, m_res1 = '0, p_res0 = '0, p_res1 = '0;
  logic [7:0]   m_ca0 = '0, m_cb0 = '0, m_ca1 = '0, m_cb1 = '0;
  logic [W-1:0] m_a = '0, m_b = '0;
  int           m_pos = 0, m_len = 0, m_inj = NB;

  function automatic logic [2:0] byte_flags(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    if (a == b) return 3'b001;
    if (sgn ? ($signed(a) > $signed(b)) : (a > b)) return 3'b100;
    return 3'b010;
  endfunction

  function automatic logic [7:0] shown(input logic [W-1:0] w, input int k, input bit sgn);
    logic [7:0] v;
    v = w[8*k +: 8];
    if (!(sgn && k == NB - 1)) v[7] = ~v[7];
    return v;
  endfunction

  always @(posedge clk) begin
    if (drv_rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_res0 = '0; m_res1 = '0;
      m_ca0 = '0; m_cb0 = '0; m_ca1 = '0; m_cb1 = '0;
    end else if (m_busy) begin
      m_pos = m_pos + 1;
      if (m_pos == m_len) begin
        m_busy = 1'b0; m_done = 1'b1; m_err = p_err;
        m_res0 = p_res0; m_res1 = p_res1;
      end else begin
        m_ca0 = shown(m_a, NB - 1 - m_pos, 1'b1); m_cb0 = shown(m_b, NB - 1 - m_pos, 1'b1);
        m_ca1 = shown(m_a, NB - 1 - m_pos, 1'b0); m_cb1 = shown(m_b, NB - 1 - m_pos, 1'b0);
      end
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (drv_start) begin
        m_a = drv_a; m_b = drv_b; m_inj = drv_inj;
        p_err = 1'b0; p_res0 = 3'b001; p_res1 = 3'b001; m_len = NB;
        for (int j = 0; j < NB; j++) begin
          if (j == m_inj) begin
            p_err = 1'b1;
            continue;
          end
          if (m_a[8*(NB-1-j) +: 8] != m_b[8*(NB-1-j) +: 8]) begin
            p_res0 = byte_flags(m_a[8*(NB-1-j) +: 8], m_b[8*(NB-1-j) +: 8], j == 0);
            p_res1 = byte_flags(m_a[8*(NB-1-j) +: 8], m_b[8*(NB-1-j) +: 8], 1'b0);
            m_len  = j + 1;
            break;
          end
        end
        m_busy = 1'b1; m_pos = 0;
        m_ca0 = shown(m_a, NB - 1, 1'b1); m_cb0 = shown(m_b, NB - 1, 1'b1);
        m_ca1 = shown(m_a, NB - 1, 1'b0); m_cb1 = shown(m_b, NB - 1, 1'b0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy_s",  32'(bus0.busy_op),  32'(m_busy));
    chk("done_s",  32'(bus0.done_op),  32'(m_done));
    chk("err_s",   32'(bus0.err_op),   32'(m_err));
    chk("res_s",   32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b}), 32'(m_res0));
    chk("cmpa_s",  32'(bus0.cmp_a_op), 32'(m_ca0));
    chk("cmpb_s",  32'(bus0.cmp_b_op), 32'(m_cb0));
    chk("casc_s",  32'({bus0.cmp_a_ip_G_op, bus0.cmp_b_ip_G_op, bus0.cmp_a_ip_E_b_op}), 32'h1);
    chk("busy_u",  32'(bus1.busy_op),  32'(m_busy));
    chk("done_u",  32'(bus1.done_op),  32'(m_done));
    chk("err_u",   32'(bus1.err_op),   32'(m_err));
    chk("res_u",   32'({bus1.a_op_G, bus1.b_op_G, bus1.a_op_E_b}), 32'(m_res1));
    chk("cmpa_u",  32'(bus1.cmp_a_op), 32'(m_ca1));
    chk("cmpb_u",  32'(bus1.cmp_b_op), 32'(m_cb1));
    chk("casc_u",  32'({bus1.cmp_a_ip_G_op, bus1.cmp_b_ip_G_op, bus1.cmp_a_ip_E_b_op}), 32'h1);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    inj_now = m_busy && (m_pos == m_inj);
  endtask

  logic [7:0] seq_a [8];
  logic [7:0] seq_b [8];

  // Launch one operation and stop at the negedge of its done cycle (lat 0 = no done seen).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse,
                        input int inj, output int lat, output bit busy1);
    drv_a = a; drv_b = b; drv_start = 1'b1; drv_inj = inj;
    lat = 0; busy1 = 1'b0;
    for (int n = 1; n <= NB + 3; n++) begin
      cycle();
      if (n == 1) busy1 = bus0.busy_op;
      if (bus0.busy_op) begin
        seq_a[n-1] = bus0.cmp_a_op;
        seq_b[n-1] = bus0.cmp_b_op;
      end
      if (repulse && n < 3) begin
        drv_start = 1'b1; drv_a = ~a; drv_b = ~b;
      end else begin
        drv_start = 1'b0;
      end
      if (bus0.done_op) begin
        lat = n;
        break;
      end
    end
    drv_start = 1'b0;
    drv_inj   = NB;
  endtask

  initial begin
    int lat;
    bit b1;
    logic [7:0] ea [4];
    logic [7:0] eb [4];

    // Reset held two cycles with a start request that must be ignored.
    drv_rst = 1'b1; drv_start = 1'b1; drv_a = 32'h1; drv_b = 32'h2;
    cycle();
    cycle();
    chk("rst_busy", 32'(bus0.busy_op), 32'h0);
    chk("rst_done", 32'(bus0.done_op), 32'h0);
    chk("rst_res",  32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b, bus0.err_op}), 32'h0);
    chk("rst_cmp",  32'({bus0.cmp_a_op, bus0.cmp_b_op}), 32'h0);
    drv_rst = 1'b0; drv_start = 1'b0;
    cycle();
    chk("rst_start_ignored", 32'(bus0.busy_op), 32'h0);

    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, NB, lat, b1);
    chk("neg_vs_pos_lat", 32'(lat), 32'd2);
    chk("neg_vs_pos_res", 32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b}), 32'h2);
    chk("neg_vs_pos_bytes", 32'({seq_a[0], seq_b[0]}), 32'h807F);
    chk("unsigned_ms_res", 32'({bus1.a_op_G, bus1.b_op_G, bus1.a_op_E_b}), 32'h4);

    run_op(32'h12345678, 32'h12345677, 1'b0, NB, lat, b1);
    ea = '{8'h12, 8'hB4, 8'hD6, 8'hF8};
    eb = '{8'h12, 8'hB4, 8'hD6, 8'hF7};
    chk("lsb_diff_lat", 32'(lat), 32'd5);
    chk("lsb_diff_res", 32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b}), 32'h4);
    for (int i = 0; i < NB; i++) chk("lsb_diff_bytes", 32'({seq_a[i], seq_b[i]}), 32'({ea[i], eb[i]}));

    run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, NB, lat, b1);
    chk("equal_lat", 32'(lat), 32'd5);
    chk("equal_res", 32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b, bus0.err_op}), 32'h2);

    run_op(32'h00000080, 32'h0000007F, 1'b0, NB, lat, b1);
    chk("low_unsigned_res", 32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b}), 32'h4);

    run_op(32'h11223344, 32'h11223344, 1'b0, 1, lat, b1);
    chk("bad_resp_lat", 32'(lat), 32'd5);
    chk("bad_resp_err", 32'({bus0.a_op_E_b, bus0.err_op}), 32'h3);

    run_op(32'h00000001, 32'h00000002, 1'b1, NB, lat, b1);
    chk("repulse_lat", 32'(lat), 32'd5);
    chk("repulse_res", 32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b}), 32'h2);

    run_op(32'h00000005, 32'h00000005, 1'b0, NB, lat, b1);
    run_op(32'h01000000, 32'h02000000, 1'b0, NB, lat, b1);
    chk("b2b_busy", 32'(b1), 32'h1);
    chk("b2b_lat",  32'(lat), 32'd2);
    chk("b2b_res",  32'({bus0.a_op_G, bus0.b_op_G, bus0.a_op_E_b}), 32'h2);

    drv_a = 32'hCAFEF00D; drv_b = 32'hCAFEF00D; drv_start = 1'b1;
    cycle();
    drv_start = 1'b0;
    cycle();
    drv_rst = 1'b1;
    cycle();
    chk("midrun_rst", 32'({bus0.busy_op, bus0.done_op}), 32'h0);
    drv_rst = 1'b0;
    cycle();
    chk("midrun_rst_nodone", 32'({bus0.busy_op, bus0.done_op}), 32'h0);

    // Randomized traffic biased toward long equal prefixes.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      drv_rst   = ($urandom_range(0, 199) == 0);
      drv_start = ($urandom_range(0, 2) == 0);
      drv_a     = $urandom;
      case ($urandom_range(0, 3))
        0: drv_b = $urandom;
        1: drv_b = drv_a;
        default: begin
          drv_b = drv_a;
          drv_b[8*$urandom_range(0, NB-1) +: 8] = 8'($urandom);
        end
      endcase
      drv_inj = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB-1)) : NB;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
